// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared sizes and types for the round-robin index arbiter
package rr_arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after start
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  idx_t             start,
    output logic             found,
    output idx_t             idx
);
    logic [N_REQ-1:0] rot;
    idx_t             off;

    always_comb begin
        // Rotating right by start puts the highest-priority requester at bit 0.
        rot = N_REQ'({req, req} >> start);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = idx_t'(i);
            end
        end
        found = |req;
        idx   = start + off;
    end
endmodule

// File: rtl/rr_index_arbiter.sv
// rtl/rr_index_arbiter.sv - round-robin arbiter driving {number,en} into the grant decoder
module rr_index_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output idx_t             number,
    output logic             en,
    output logic             forced
);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    idx_t              ptr_q, ptr_d;
    idx_t              number_q, number_d;
    logic              en_q, en_d;
    logic              forced_q, forced_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    idx_t pick_start;
    idx_t pick_idx;
    logic pick_found;
    logic timeout;
    logic release_now;

    // While busy the search begins just past the current holder, so it is considered last.
    assign pick_start = (state_q == IDLE) ? ptr_q : number_q + 1'b1;

    rr_pick u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign timeout     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign release_now = done || !req[number_q] || timeout;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        number_d = number_q;
        en_d     = en_q;
        hold_d   = hold_q;
        forced_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    number_d = pick_idx;
                    en_d     = 1'b1;
                    hold_d   = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_d    = number_q + 1'b1;
                    forced_d = timeout && !done;
                    hold_d   = '0;
                    if (pick_found) begin
                        number_d = pick_idx;
                    end else begin
                        en_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            number_q <= '0;
            en_q     <= 1'b0;
            forced_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            number_q <= number_d;
            en_q     <= en_d;
            forced_q <= forced_d;
            hold_q   <= hold_d;
        end
    end

    assign number = number_q;
    assign en     = en_q;
    assign forced = forced_q;
endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb/tb_rr_index_arbiter.sv - directed scoreboard bench for rr_index_arbiter
module tb_rr_index_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'hFF;
    logic       done = 1'b1;
    logic [2:0] number;
    logic       en;
    logic       forced;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       en;
        logic [2:0] num;
        logic       forced;
    } exp_t;

    exp_t exp_q[$];

    logic       mon_on = 1'b0;
    logic [7:0] req_s;
    logic       rst_s;
    logic       en_prev = 1'b0;
    logic [2:0] num_prev = 3'd0;

    rr_index_arbiter #(.MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .number (number),
        .en     (en),
        .forced (forced)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic r, input logic [7:0] rq, input logic d,
                        input logic e_en, input logic [2:0] e_num, input logic e_f);
        exp_t e;
        exp_t got;
        logic [7:0] y_obs;
        logic [7:0] y_exp;
        rst  = r;
        req  = rq;
        done = d;
        e.tag = tag; e.en = e_en; e.num = e_num; e.forced = e_f;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        checks++;
        assert (en === got.en) else begin
            errors++;
            $error("FAIL %s.en observed=%0b expected=%0b", got.tag, en, got.en);
        end
        checks++;
        assert (number === got.num) else begin
            errors++;
            $error("FAIL %s.number observed=%0d expected=%0d", got.tag, number, got.num);
        end
        checks++;
        assert (forced === got.forced) else begin
            errors++;
            $error("FAIL %s.forced observed=%0b expected=%0b", got.tag, forced, got.forced);
        end
        y_obs = en ? (8'b1 << number) : 8'b0;
        y_exp = got.en ? (8'b1 << got.num) : 8'b0;
        checks++;
        assert (y_obs === y_exp) else begin
            errors++;
            $error("FAIL %s.Y observed=%0h expected=%0h", got.tag, y_obs, y_exp);
        end
    endtask

    always @(posedge clk) begin
        req_s = req;
        rst_s = rst;
        #1;
        if (mon_on && !rst_s) begin
            if (en) begin
                checks++;
                assert (req_s[number] === 1'b1) else begin
                    errors++;
                    $error("FAIL inv_req observed=%0b expected=1 number=%0d", req_s[number], number);
                end
            end
            if (number !== num_prev) begin
                checks++;
                assert ((en_prev || en) === 1'b1) else begin
                    errors++;
                    $error("FAIL inv_number observed=%0d expected=%0d", number, num_prev);
                end
            end
        end
        en_prev  = en;
        num_prev = number;
    end

    initial begin
        #2;
        // reset held with everything asserted
        step("rst0", 1, 8'hFF, 1, 0, 3'd0, 0);
        step("rst1", 1, 8'hFF, 1, 0, 3'd0, 0);
        mon_on = 1'b1;

        // single grant, release to idle, pointer moves past it
        step("g4",      0, 8'h10, 0, 1, 3'd4, 0);
        step("rel4",    0, 8'h00, 1, 0, 3'd4, 0);
        step("ptr5",    0, 8'h21, 0, 1, 3'd5, 0);

        // back-to-back rotation through all requesters
        step("rst_mid", 1, 8'hFF, 1, 0, 3'd0, 0);
        step("rot0",    0, 8'hFF, 1, 1, 3'd0, 0);
        for (int i = 1; i <= 8; i++) begin
            step("rot", 0, 8'hFF, 1, 1, 3'(i % 8), 0);
        end

        // wrap alternation between 7 and 0
        step("to6",     0, 8'h40, 1, 1, 3'd6, 0);
        step("idle6",   0, 8'h00, 1, 0, 3'd6, 0);
        step("alt7a",   0, 8'h81, 0, 1, 3'd7, 0);
        step("alt0",    0, 8'h81, 1, 1, 3'd0, 0);
        step("alt7b",   0, 8'h81, 1, 1, 3'd7, 0);
        step("abandon", 0, 8'h01, 0, 1, 3'd0, 0);

        // hold timeout
        step("rst_to",  1, 8'h03, 0, 0, 3'd0, 0);
        step("hold0",   0, 8'h03, 0, 1, 3'd0, 0);
        for (int i = 1; i <= 3; i++) begin
            step("hold", 0, 8'h03, 0, 1, 3'd0, 0);
        end
        step("forced",  0, 8'h03, 0, 1, 3'd1, 1);
        step("after_f", 0, 8'h03, 0, 1, 3'd1, 0);
        step("hold1b",  0, 8'h03, 0, 1, 3'd1, 0);
        step("hold1c",  0, 8'h03, 0, 1, 3'd1, 0);
        step("to_done", 0, 8'h03, 1, 1, 3'd0, 0);

        // reset while busy
        step("g3",      0, 8'h08, 1, 1, 3'd3, 0);
        step("rst_b",   1, 8'hFF, 0, 0, 3'd0, 0);
        step("post_r",  0, 8'hFF, 0, 1, 3'd0, 0);

        // done while idle is ignored
        step("to_idle", 0, 8'h00, 0, 0, 3'd0, 0);
        step("done_id", 0, 8'h00, 1, 0, 3'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
